// File: rtl/axi_sram_bridge_mp.sv
// Multi-port SRAM-like to AXI3 single-beat master bridge. It tracks several reads per port,
// keeps an in-order queue of pending writes, and holds back reads that hit a queued write.
module axi_sram_bridge_mp #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int RD_OUTST  = 2,
  parameter int WR_OUTST  = 2
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [NUM_PORTS-1:0]          p_req,
  input  logic [NUM_PORTS-1:0]          p_wr,
  input  logic [2*NUM_PORTS-1:0]        p_size,
  input  logic [ADDR_W*NUM_PORTS-1:0]   p_addr,
  input  logic [4*NUM_PORTS-1:0]        p_wstrb,
  input  logic [DATA_W*NUM_PORTS-1:0]   p_wdata,
  output logic [NUM_PORTS-1:0]          p_addr_ok,
  output logic [NUM_PORTS-1:0]          p_data_ok,
  output logic [DATA_W-1:0]             p_rdata,
  output logic [ID_W-1:0]               arid,
  output logic [ADDR_W-1:0]             araddr,
  output logic [7:0]                    arlen,
  output logic [2:0]                    arsize,
  output logic [1:0]                    arburst,
  output logic [1:0]                    arlock,
  output logic [3:0]                    arcache,
  output logic [2:0]                    arprot,
  output logic                          arvalid,
  input  logic                          arready,
  input  logic [ID_W-1:0]               rid,
  input  logic [DATA_W-1:0]             rdata,
  input  logic [1:0]                    rresp,
  input  logic                          rlast,
  input  logic                          rvalid,
  output logic                          rready,
  output logic [ID_W-1:0]               awid,
  output logic [ADDR_W-1:0]             awaddr,
  output logic [7:0]                    awlen,
  output logic [2:0]                    awsize,
  output logic [1:0]                    awburst,
  output logic [1:0]                    awlock,
  output logic [3:0]                    awcache,
  output logic [2:0]                    awprot,
  output logic                          awvalid,
  input  logic                          awready,
  output logic [ID_W-1:0]               wid,
  output logic [DATA_W-1:0]             wdata,
  output logic [3:0]                    wstrb,
  output logic                          wlast,
  output logic                          wvalid,
  input  logic                          wready,
  input  logic [ID_W-1:0]               bid,
  input  logic [1:0]                    bresp,
  input  logic                          bvalid,
  output logic                          bready
);

  localparam int CNT_W    = 2;
  localparam int WQ_CNT_W = $clog2(WR_OUTST + 1);
  localparam int WA_W     = ADDR_W - 2;
  localparam logic [CNT_W-1:0]    RD_MAX = CNT_W'(RD_OUTST);
  localparam logic [WQ_CNT_W-1:0] WR_MAX = WQ_CNT_W'(WR_OUTST);

  typedef enum logic {AR_IDLE, AR_SEND} ar_state_e;
  typedef enum logic {W_IDLE, W_SEND} w_state_e;

  ar_state_e ar_state_q, ar_state_d;
  w_state_e  w_state_q, w_state_d;

  logic [ID_W-1:0]   arid_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [2:0]        arsize_q;
  logic              arvalid_q, arvalid_d;
  logic [ID_W-1:0]   awid_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [2:0]        awsize_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wstrb_q;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;

  logic [CNT_W-1:0]    rd_cnt_q [NUM_PORTS];
  logic [ID_W-1:0]     wq_id_q   [WR_OUTST];
  logic [ID_W-1:0]     wq_id_d   [WR_OUTST];
  logic [WA_W-1:0]     wq_addr_q [WR_OUTST];
  logic [WA_W-1:0]     wq_addr_d [WR_OUTST];
  logic [WQ_CNT_W-1:0] wq_cnt_q, wq_cnt_d;
  logic                wq_pop;

  logic [NUM_PORTS-1:0] wr_pend, addr_hit, r_hit, b_hit;
  logic [NUM_PORTS-1:0] rd_onehot, wr_onehot;
  logic                 rd_gnt, wr_gnt;
  logic [ID_W-1:0]      rd_sel, wr_sel;
  logic [ADDR_W-1:0]    rd_addr, wr_addr;
  logic [1:0]           rd_size, wr_size;
  logic [DATA_W-1:0]    wr_data;
  logic [3:0]           wr_strb;

  // Per-port view of the write queue: pending writes and word-address hazards.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    wr_pend  = '0;
    addr_hit = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int j = 0; j < WR_OUTST; j++) begin
        if (WQ_CNT_W'(j) < wq_cnt_q) begin
          if (wq_id_q[j] == ID_W'(i)) wr_pend[i] = 1'b1;
          if (wq_addr_q[j] == p_addr[i*ADDR_W+2 +: WA_W]) addr_hit[i] = 1'b1;
        end
      end
    end
  end

  // Later iterations overwrite earlier ones, so the highest eligible index wins.
  always_comb begin
    rd_gnt = 1'b0; rd_sel = '0; rd_addr = '0; rd_size = '0; rd_onehot = '0;
    wr_gnt = 1'b0; wr_sel = '0; wr_addr = '0; wr_size = '0; wr_onehot = '0;
    wr_data = '0; wr_strb = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (aresetn && ar_state_q == AR_IDLE && p_req[i] && !p_wr[i] &&
          rd_cnt_q[i] < RD_MAX && !wr_pend[i] && !addr_hit[i]) begin
        rd_gnt       = 1'b1;
        rd_sel       = ID_W'(i);
        rd_addr      = p_addr[i*ADDR_W +: ADDR_W];
        rd_size      = p_size[2*i +: 2];
        rd_onehot    = '0;
        rd_onehot[i] = 1'b1;
      end
      if (aresetn && w_state_q == W_IDLE && p_req[i] && p_wr[i] &&
          rd_cnt_q[i] == '0 && wq_cnt_q < WR_MAX) begin
        wr_gnt       = 1'b1;
        wr_sel       = ID_W'(i);
        wr_addr      = p_addr[i*ADDR_W +: ADDR_W];
        wr_size      = p_size[2*i +: 2];
        wr_data      = p_wdata[i*DATA_W +: DATA_W];
        wr_strb      = p_wstrb[4*i +: 4];
        wr_onehot    = '0;
        wr_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      r_hit[i] = rvalid && (rid == ID_W'(i));
      b_hit[i] = bvalid && (bid == ID_W'(i));
    end
  end

  always_comb begin
    ar_state_d = ar_state_q;
    arvalid_d  = arvalid_q;
    case (ar_state_q)
      AR_IDLE: if (rd_gnt) begin
        ar_state_d = AR_SEND;
        arvalid_d  = 1'b1;
      end
      AR_SEND: if (arready) begin
        ar_state_d = AR_IDLE;
        arvalid_d  = 1'b0;
      end
      default: ar_state_d = AR_IDLE;
    endcase
  end

  // AW and W retire independently; the slot frees once both have handshaken.
  always_comb begin
    w_state_d = w_state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    case (w_state_q)
      W_IDLE: if (wr_gnt) begin
        w_state_d = W_SEND;
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
      end
      W_SEND: begin
        if (awready) awvalid_d = 1'b0;
        if (wready)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write queue kept oldest-first in entry 0; B responses arrive in order.
  assign wq_pop = bvalid && (wq_cnt_q != '0);

  always_comb begin
    wq_id_d   = wq_id_q;
    wq_addr_d = wq_addr_q;
    wq_cnt_d  = wq_cnt_q;
    if (wq_pop) begin
      for (int j = 0; j < WR_OUTST - 1; j++) begin
        wq_id_d[j]   = wq_id_q[j+1];
        wq_addr_d[j] = wq_addr_q[j+1];
      end
      wq_id_d[WR_OUTST-1]   = '0;
      wq_addr_d[WR_OUTST-1] = '0;
      wq_cnt_d = wq_cnt_q - WQ_CNT_W'(1);
    end
    if (wr_gnt) begin
      for (int j = 0; j < WR_OUTST; j++) begin
        if (WQ_CNT_W'(j) == wq_cnt_d) begin
          wq_id_d[j]   = wr_sel;
          wq_addr_d[j] = wr_addr[ADDR_W-1:2];
        end
      end
      wq_cnt_d = wq_cnt_d + WQ_CNT_W'(1);
    end
  end

  always_ff @(posedge aclk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!aresetn) begin
      ar_state_q <= AR_IDLE;
      w_state_q  <= W_IDLE;
      arvalid_q  <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      arid_q     <= '0;
      araddr_q   <= '0;
      arsize_q   <= '0;
      awid_q     <= '0;
      awaddr_q   <= '0;
      awsize_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wq_cnt_q   <= '0;
      // NOTE: the queue is only a few flops, so it is cleared outright rather than relying on the count.
      for (int j = 0; j < WR_OUTST; j++) begin
        wq_id_q[j]   <= '0;
        wq_addr_q[j] <= '0;
      end
      for (int i = 0; i < NUM_PORTS; i++) rd_cnt_q[i] <= '0;
    end else begin
      ar_state_q <= ar_state_d;
      w_state_q  <= w_state_d;
      arvalid_q  <= arvalid_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      wq_cnt_q   <= wq_cnt_d;
      wq_id_q    <= wq_id_d;
      wq_addr_q  <= wq_addr_d;
      if (rd_gnt) begin
        arid_q   <= rd_sel;
        araddr_q <= rd_addr;
        arsize_q <= {1'b0, rd_size};
      end
      if (wr_gnt) begin
        awid_q   <= wr_sel;
        awaddr_q <= wr_addr;
        awsize_q <= {1'b0, wr_size};
        wdata_q  <= wr_data;
        wstrb_q  <= wr_strb;
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (rd_onehot[i] && !r_hit[i])
          rd_cnt_q[i] <= rd_cnt_q[i] + CNT_W'(1);
        else if (!rd_onehot[i] && r_hit[i] && rd_cnt_q[i] != '0)
          rd_cnt_q[i] <= rd_cnt_q[i] - CNT_W'(1);
      end
    end
  end

  assign p_addr_ok = rd_onehot | wr_onehot;
  assign p_data_ok = aresetn ? (r_hit | b_hit) : '0;
  assign p_rdata   = rdata;

  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arsize  = arsize_q;
  assign arvalid = arvalid_q;
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign rready  = 1'b1;

  assign awid    = awid_q;
  assign awaddr  = awaddr_q;
  assign awsize  = awsize_q;
  assign awvalid = awvalid_q;
  assign awlen   = 8'd0;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;

  assign wid    = awid_q;
  assign wdata  = wdata_q;
  assign wstrb  = wstrb_q;
  assign wlast  = 1'b1;
  assign wvalid = wvalid_q;
  assign bready = 1'b1;

  logic unused_ok;
  assign unused_ok = ^{rresp, rlast, bresp};

endmodule

// File: tb/tb_axi_sram_bridge_mp.sv
// Directed bench for axi_sram_bridge_mp: inputs change 1ns after the rising edge and
// outputs are checked on the falling edge against hand-computed values.
module tb_axi_sram_bridge_mp;

  localparam int NP = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;

  logic            aclk, aresetn;
  logic [NP-1:0]   p_req, p_wr;
  logic [2*NP-1:0] p_size;
  logic [AW*NP-1:0] p_addr;
  logic [4*NP-1:0] p_wstrb;
  logic [DW*NP-1:0] p_wdata;
  logic [NP-1:0]   p_addr_ok, p_data_ok;
  logic [DW-1:0]   p_rdata;
  logic [IW-1:0]   arid, awid, wid, rid, bid;
  logic [AW-1:0]   araddr, awaddr;
  logic [7:0]      arlen, awlen;
  logic [2:0]      arsize, awsize, arprot, awprot;
  logic [1:0]      arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]      arcache, awcache, wstrb;
  logic            arvalid, arready, rlast, rvalid, rready;
  logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [DW-1:0]   rdata, wdata;

  int tests_run    = 0;
  int tests_failed = 0;

  axi_sram_bridge_mp #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW),
                       .RD_OUTST(2), .WR_OUTST(2)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .p_req(p_req), .p_wr(p_wr), .p_size(p_size), .p_addr(p_addr),
    .p_wstrb(p_wstrb), .p_wdata(p_wdata),
    .p_addr_ok(p_addr_ok), .p_data_ok(p_data_ok), .p_rdata(p_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic sample();
    @(negedge aclk);
  endtask

  task automatic set_port(input int p, input logic req, input logic wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data);
    p_req[p]          = req;
    p_wr[p]           = wr;
    p_size[2*p +: 2]  = size;
    p_addr[AW*p +: AW] = addr;
    p_wstrb[4*p +: 4] = strb;
    p_wdata[DW*p +: DW] = data;
  endtask

  task automatic clear_inputs();
    p_req = '0; p_wr = '0; p_size = '0; p_addr = '0; p_wstrb = '0; p_wdata = '0;
    arready = 0; awready = 0; wready = 0;
    rid = '0; rdata = '0; rresp = '0; rlast = 0; rvalid = 0;
    bid = '0; bresp = '0; bvalid = 0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    clear_inputs();
    repeat (3) step();
    sample();
    tests_run++; if (arvalid !== 1'b0) begin tests_failed++; $display("FAIL reset arvalid: got %b expected 0", arvalid); end
    tests_run++; if (awvalid !== 1'b0 || wvalid !== 1'b0) begin tests_failed++; $display("FAIL reset aw/wvalid: got %b/%b expected 0/0", awvalid, wvalid); end
    tests_run++; if (p_addr_ok !== 2'b00 || p_data_ok !== 2'b00) begin tests_failed++; $display("FAIL reset ok: got %b/%b expected 00/00", p_addr_ok, p_data_ok); end
    tests_run++; if (wlast !== 1'b1 || rready !== 1'b1 || bready !== 1'b1) begin tests_failed++; $display("FAIL reset wlast/rready/bready: got %b%b%b expected 111", wlast, rready, bready); end
    tests_run++; if (araddr !== 32'h0 || arid !== 4'h0 || awaddr !== 32'h0) begin tests_failed++; $display("FAIL reset regs: araddr %h arid %h awaddr %h expected 0", araddr, arid, awaddr); end
    tests_run++; if (arburst !== 2'b01 || awburst !== 2'b01 || arlen !== 8'd0 || awcache !== 4'd0) begin tests_failed++; $display("FAIL constants: arburst %b awburst %b arlen %h awcache %h", arburst, awburst, arlen, awcache); end
    step();
    aresetn = 1'b1;
  endtask

  task automatic test_read_basic();
    int held;
    step();
    set_port(0, 1, 0, 2'd2, 32'h1000, 4'h0, 32'h0);
    sample();
    tests_run++; if (p_addr_ok !== 2'b01 || arvalid !== 1'b0) begin tests_failed++; $display("FAIL rd_basic grant: addr_ok %b arvalid %b expected 01/0", p_addr_ok, arvalid); end
    step();
    set_port(0, 0, 0, 2'd0, 32'h0, 4'h0, 32'h0);
    sample();
    tests_run++; if (p_addr_ok !== 2'b00) begin tests_failed++; $display("FAIL rd_basic addr_ok pulse: got %b expected 00", p_addr_ok); end
    held = 0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) step();
      if (k == 2) arready = 1;
      sample();
      if (arvalid === 1'b1 && araddr === 32'h1000 && arid === 4'd0 && arsize === 3'd2) held++;
    end
    tests_run++; if (held != 3) begin tests_failed++; $display("FAIL rd_basic ar hold: %0d stable cycles, expected 3", held); end
    step();
    arready = 0;
    sample();
    tests_run++; if (arvalid !== 1'b0) begin tests_failed++; $display("FAIL rd_basic ar drop: arvalid %b expected 0", arvalid); end
    step(); step();
    rvalid = 1; rid = 4'd0; rdata = 32'hDEADBEEF;
    sample();
    tests_run++; if (p_data_ok !== 2'b01 || p_rdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL rd_basic data: data_ok %b rdata %h expected 01/deadbeef", p_data_ok, p_rdata); end
    step();
    rvalid = 0;
    sample();
    tests_run++; if (p_data_ok !== 2'b00) begin tests_failed++; $display("FAIL rd_basic data_ok drop: got %b expected 00", p_data_ok); end
  endtask

  task automatic test_read_priority();
    step();
    set_port(0, 1, 0, 2'd2, 32'h3000, 4'h0, 32'h0);
    set_port(1, 1, 0, 2'd2, 32'h4000, 4'h0, 32'h0);
    sample();
    tests_run++; if (p_addr_ok !== 2'b10) begin tests_failed++; $display("FAIL prio first grant: got %b expected 10", p_addr_ok); end
    step();
    set_port(1, 0, 0, 2'd0, 32'h0, 4'h0, 32'h0);
    arready = 1;
    sample();
    tests_run++; if (p_addr_ok !== 2'b00 || arvalid !== 1'b1 || arid !== 4'd1 || araddr !== 32'h4000) begin tests_failed++; $display("FAIL prio ar1: ok %b arvalid %b arid %h araddr %h expected 00/1/1/4000", p_addr_ok, arvalid, arid, araddr); end
    step();
    arready = 0;
    sample();
    tests_run++; if (p_addr_ok !== 2'b01) begin tests_failed++; $display("FAIL prio second grant: got %b expected 01", p_addr_ok); end
    step();
    set_port(0, 0, 0, 2'd0, 32'h0, 4'h0, 32'h0);
    arready = 1;
    sample();
    tests_run++; if (arvalid !== 1'b1 || arid !== 4'd0 || araddr !== 32'h3000) begin tests_failed++; $display("FAIL prio ar0: arvalid %b arid %h araddr %h expected 1/0/3000", arvalid, arid, araddr); end
    step();
    arready = 0;
    rvalid = 1; rid = 4'd0; rdata = 32'h00003333;
    sample();
    tests_run++; if (p_data_ok !== 2'b01 || p_rdata !== 32'h00003333) begin tests_failed++; $display("FAIL prio r0: data_ok %b rdata %h expected 01/00003333", p_data_ok, p_rdata); end
    step();
    rid = 4'd1; rdata = 32'h00004444;
    sample();
    tests_run++; if (p_data_ok !== 2'b10 || p_rdata !== 32'h00004444) begin tests_failed++; $display("FAIL prio r1: data_ok %b rdata %h expected 10/00004444", p_data_ok, p_rdata); end
    step();
    rvalid = 0;
  endtask

  task automatic test_read_outstanding();
    step();
    set_port(1, 1, 0, 2'd2, 32'h5000, 4'h0, 32'h0);
    sample();
    tests_run++; if (p_addr_ok !== 2'b10) begin tests_failed++; $display("FAIL outst read1: got %b expected 10", p_addr_ok); end
    step();
    set_port(1, 1, 0, 2'd2, 32'h5004, 4'h0, 32'h0);
    arready = 1;
    sample();
    tests_run++; if (p_addr_ok !== 2'b00) begin tests_failed++; $display("FAIL outst busy slot: got %b expected 00", p_addr_ok); end
    step();
    arready = 0;
    sample();
    tests_run++; if (p_addr_ok !== 2'b10) begin tests_failed++; $display("FAIL outst read2: got %b expected 10", p_addr_ok); end
    step();
    set_port(1, 1, 0, 2'd2, 32'h5008, 4'h0, 32'h0);
    arready = 1;
    sample();
    step();
    arready = 0;
    sample();
    tests_run++; if (p_addr_ok !== 2'b00) begin tests_failed++; $display("FAIL outst limit: got %b expected 00", p_addr_ok); end
    step();
    sample();
    tests_run++; if (p_addr_ok !== 2'b00) begin tests_failed++; $display("FAIL outst limit hold: got %b expected 00", p_addr_ok); end
    step();
    rvalid = 1; rid = 4'd1; rdata = 32'h55550000;
    sample();
    tests_run++; if (p_addr_ok !== 2'b00 || p_data_ok !== 2'b10) begin tests_failed++; $display("FAIL outst rvalid cycle: ok %b data_ok %b expected 00/10", p_addr_ok, p_data_ok); end
    step();
    rvalid = 0;
    sample();
    tests_run++; if (p_addr_ok !== 2'b10) begin tests_failed++; $display("FAIL outst read3: got %b expected 10", p_addr_ok); end
    step();
    set_port(1, 0, 0, 2'd0, 32'h0, 4'h0, 32'h0);
    arready = 1;
    sample();
    tests_run++; if (araddr !== 32'h5008 || arid !== 4'd1) begin tests_failed++; $display("FAIL outst ar3: araddr %h arid %h expected 5008/1", araddr, arid); end
    step();
    arready = 0;
    rvalid = 1; rid = 4'd1; rdata = 32'h55550004;
    sample();
    step();
    rdata = 32'h55550008;
    sample();
    tests_run++; if (p_data_ok !== 2'b10 || p_rdata !== 32'h55550008) begin tests_failed++; $display("FAIL outst last r: data_ok %b rdata %h expected 10/55550008", p_data_ok, p_rdata); end
    step();
    rvalid = 0;
  endtask

  task automatic test_raw_hazard();
    step();
    set_port(1, 1, 1, 2'd2, 32'h2000, 4'hF, 32'h12345678);
    sample();
    tests_run++; if (p_addr_ok !== 2'b10) begin tests_failed++; $display("FAIL raw write grant: got %b expected 10", p_addr_ok); end
    step();
    set_port(1, 0, 0, 2'd0, 32'h0, 4'h0, 32'h0);
    set_port(0, 1, 0, 2'd1, 32'h2002, 4'h0, 32'h0);
    awready = 1; wready = 1;
    sample();
    tests_run++; if (awvalid !== 1'b1 || wvalid !== 1'b1 || awaddr !== 32'h2000 || awid !== 4'd1 || wid !== 4'd1) begin tests_failed++; $display("FAIL raw aw/w: awv %b wv %b awaddr %h awid %h wid %h expected 1/1/2000/1/1", awvalid, wvalid, awaddr, awid, wid); end
    tests_run++; if (wdata !== 32'h12345678 || wstrb !== 4'hF || awsize !== 3'd2 || wlast !== 1'b1) begin tests_failed++; $display("FAIL raw w fields: wdata %h wstrb %h awsize %0d wlast %b expected 12345678/f/2/1", wdata, wstrb, awsize, wlast); end
    tests_run++; if (p_addr_ok !== 2'b00) begin tests_failed++; $display("FAIL raw blocked1: got %b expected 00", p_addr_ok); end
    step();
    awready = 0; wready = 0;
    sample();
    tests_run++; if (awvalid !== 1'b0 || wvalid !== 1'b0 || p_addr_ok !== 2'b00) begin tests_failed++; $display("FAIL raw blocked2: awv %b wv %b ok %b expected 0/0/00", awvalid, wvalid, p_addr_ok); end
    step();
    bvalid = 1; bid = 4'd1;
    sample();
    tests_run++; if (p_data_ok !== 2'b10 || p_addr_ok !== 2'b00) begin tests_failed++; $display("FAIL raw bvalid cycle: data_ok %b ok %b expected 10/00", p_data_ok, p_addr_ok); end
    step();
    bvalid = 0;
    sample();
    tests_run++; if (p_addr_ok !== 2'b01 || arvalid !== 1'b0) begin tests_failed++; $display("FAIL raw release: ok %b arvalid %b expected 01/0", p_addr_ok, arvalid); end
    step();
    set_port(0, 0, 0, 2'd0, 32'h0, 4'h0, 32'h0);
    arready = 1;
    sample();
    tests_run++; if (arvalid !== 1'b1 || araddr !== 32'h2002 || arsize !== 3'd1) begin tests_failed++; $display("FAIL raw ar: arvalid %b araddr %h arsize %0d expected 1/2002/1", arvalid, araddr, arsize); end
    step();
    arready = 0;
    rvalid = 1; rid = 4'd0; rdata = 32'hAAAA5555;
    sample();
    tests_run++; if (p_data_ok !== 2'b01 || p_rdata !== 32'hAAAA5555) begin tests_failed++; $display("FAIL raw r: data_ok %b rdata %h expected 01/aaaa5555", p_data_ok, p_rdata); end
    step();
    rvalid = 0;
  endtask

  task automatic test_write_handshakes();
    step();
    set_port(1, 1, 1, 2'd1, 32'h6000, 4'h3, 32'h11112222);
    sample();
    tests_run++; if (p_addr_ok !== 2'b10) begin tests_failed++; $display("FAIL wr1 grant: got %b expected 10", p_addr_ok); end
    step();
    set_port(1, 0, 0, 2'd0, 32'h0, 4'h0, 32'h0);
    wready = 1;
    sample();
    tests_run++; if (awvalid !== 1'b1 || wvalid !== 1'b1 || wstrb !== 4'h3 || awsize !== 3'd1 || wdata !== 32'h11112222) begin tests_failed++; $display("FAIL wr1 raise: awv %b wv %b wstrb %h awsize %0d wdata %h", awvalid, wvalid, wstrb, awsize, wdata); end
    step();
    wready = 0; awready = 1;
    sample();
    tests_run++; if (awvalid !== 1'b1 || wvalid !== 1'b0 || p_data_ok !== 2'b00) begin tests_failed++; $display("FAIL wr1 w first: awv %b wv %b data_ok %b expected 1/0/00", awvalid, wvalid, p_data_ok); end
    step();
    awready = 0;
    set_port(1, 1, 1, 2'd2, 32'h6004, 4'hF, 32'h33334444);
    sample();
    tests_run++; if (awvalid !== 1'b0 || wvalid !== 1'b0 || p_addr_ok !== 2'b10) begin tests_failed++; $display("FAIL wr2 grant: awv %b wv %b ok %b expected 0/0/10", awvalid, wvalid, p_addr_ok); end
    step();
    set_port(1, 0, 0, 2'd0, 32'h0, 4'h0, 32'h0);
    awready = 1; wready = 1;
    sample();
    tests_run++; if (awvalid !== 1'b1 || wvalid !== 1'b1 || awaddr !== 32'h6004 || wdata !== 32'h33334444) begin tests_failed++; $display("FAIL wr2 raise: awv %b wv %b awaddr %h wdata %h", awvalid, wvalid, awaddr, wdata); end
    step();
    awready = 0; wready = 0;
    sample();
    tests_run++; if (awvalid !== 1'b0 || wvalid !== 1'b0 || p_data_ok !== 2'b00) begin tests_failed++; $display("FAIL wr2 same-cycle: awv %b wv %b data_ok %b expected 0/0/00", awvalid, wvalid, p_data_ok); end
    step();
    bvalid = 1; bid = 4'd1;
    sample();
    tests_run++; if (p_data_ok !== 2'b10) begin tests_failed++; $display("FAIL wr b1: data_ok %b expected 10", p_data_ok); end
    step();
    sample();
    tests_run++; if (p_data_ok !== 2'b10) begin tests_failed++; $display("FAIL wr b2: data_ok %b expected 10", p_data_ok); end
    step();
    bvalid = 0;
    sample();
    tests_run++; if (p_data_ok !== 2'b00) begin tests_failed++; $display("FAIL wr b drop: data_ok %b expected 00", p_data_ok); end
  endtask

  task automatic test_reset_mid();
    step();
    set_port(0, 1, 0, 2'd2, 32'h7000, 4'h0, 32'h0);
    sample();
    tests_run++; if (p_addr_ok !== 2'b01) begin tests_failed++; $display("FAIL rstmid grant: got %b expected 01", p_addr_ok); end
    step();
    aresetn = 0;
    set_port(0, 0, 0, 2'd0, 32'h0, 4'h0, 32'h0);
    sample();
    tests_run++; if (arvalid !== 1'b1 || p_addr_ok !== 2'b00) begin tests_failed++; $display("FAIL rstmid ar_send: arvalid %b ok %b expected 1/00", arvalid, p_addr_ok); end
    step();
    aresetn = 1;
    set_port(0, 1, 0, 2'd2, 32'h7100, 4'h0, 32'h0);
    sample();
    tests_run++; if (arvalid !== 1'b0 || araddr !== 32'h0) begin tests_failed++; $display("FAIL rstmid cleared: arvalid %b araddr %h expected 0/0", arvalid, araddr); end
    tests_run++; if (p_addr_ok !== 2'b01) begin tests_failed++; $display("FAIL rstmid regrant: got %b expected 01", p_addr_ok); end
    step();
    set_port(0, 1, 0, 2'd2, 32'h7104, 4'h0, 32'h0);
    arready = 1;
    sample();
    step();
    arready = 0;
    sample();
    tests_run++; if (p_addr_ok !== 2'b01) begin tests_failed++; $display("FAIL rstmid counter cleared: got %b expected 01", p_addr_ok); end
    step();
    set_port(0, 0, 0, 2'd0, 32'h0, 4'h0, 32'h0);
    arready = 1;
    sample();
    step();
    arready = 0;
    rvalid = 1; rid = 4'd0; rdata = 32'h71007100;
    sample();
    step();
    rdata = 32'h71047104;
    sample();
    tests_run++; if (p_data_ok !== 2'b01 || p_rdata !== 32'h71047104) begin tests_failed++; $display("FAIL rstmid r: data_ok %b rdata %h expected 01/71047104", p_data_ok, p_rdata); end
    step();
    rvalid = 0;
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_read_priority();
    test_read_outstanding();
    test_raw_hazard();
    test_write_handshakes();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axi_sram_bridge_mp.md
Name: axi_sram_bridge_mp

Overview:
- Parametrised successor to the two-port SRAM-to-AXI bridge: converts NUM_PORTS SRAM-like request/addr_ok/data_ok ports into one AXI3 single-beat master.
- Supports several outstanding reads per port, a queue of pending writes, and read-after-write hazard blocking on matching word addresses.
- Sits between the CPU core (port 0 = inst, port 1 = data, further ports for DMA/debug) and the AXI crossbar.

Parameters:
NUM_PORTS, 2, number of SRAM-side ports; port index is used as AXI ID
ADDR_W, 32, address width
DATA_W, 32, data width; only 32 is supported
ID_W, 4, AXI ID width; requires NUM_PORTS <= 2^ID_W
RD_OUTST, 2, maximum reads in flight per port (1..3)
WR_OUTST, 2, maximum writes awaiting B, whole block (1..4)

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous, active-low reset
p_req  in  NUM_PORTS  per-port request
p_wr  in  NUM_PORTS  1 = write
p_size  in  2*NUM_PORTS  0/1/2 = byte/half/word
p_addr  in  ADDR_W*NUM_PORTS  request address
p_wstrb  in  4*NUM_PORTS  write byte enables
p_wdata  in  DATA_W*NUM_PORTS  write data
p_addr_ok  out  NUM_PORTS  request accepted this cycle
p_data_ok  out  NUM_PORTS  read data or write completion this cycle
p_rdata  out  DATA_W  read data; valid with the asserted p_data_ok bit
arid/araddr/arsize/arvalid  out  ID_W/ADDR_W/3/1  AR channel
arready  in  1  AR ready
rid/rdata/rvalid  in  ID_W/DATA_W/1  R channel
rready  out  1  R ready
awid/awaddr/awsize/awvalid  out  ID_W/ADDR_W/3/1  AW channel
awready  in  1  AW ready
wid/wdata/wstrb/wlast/wvalid  out  ID_W/DATA_W/4/1/1  W channel
wready  in  1  W ready
bid/bvalid  in  ID_W/1  B channel
bready  out  1  B ready
arlen/awlen, arburst/awburst, arlock/awlock, arcache/awcache, arprot/awprot  out  8/2/2/4/3  constants: 0, 2'b01, 0, 0, 0
rresp, rlast, bresp  in  2/1/2  ignored

Behaviour:
- Reset values: arvalid, awvalid, wvalid, p_addr_ok, p_data_ok = 0. All ID, address and data registers = 0. wlast = 1. Per-port read counters = 0. Write queue empty.
- rready = bready = 1 at all times; the outstanding limits guarantee the block can always sink a response.
- Read slot FSM (AR_IDLE -> AR_SEND -> AR_IDLE):
  - In AR_IDLE, choose the highest-index port i with p_req & ~p_wr and all of:
    - rd_cnt[i] < RD_OUTST;
    - port i has no pending write;
    - p_addr[i][ADDR_W-1:2] matches no write-queue entry.
  - On grant: p_addr_ok[i] = 1 combinationally in that cycle. Latch arid = i, araddr, arsize = {0, size}. Next cycle arvalid = 1 (AR_SEND).
  - arvalid is held with stable fields until arready, then the FSM returns to AR_IDLE. Next grant comes no earlier than the following cycle.
- Write slot FSM (W_IDLE -> W_SEND -> W_IDLE):
  - In W_IDLE, choose the highest-index port with p_req & p_wr, where port i has rd_cnt[i] = 0 and the write queue has fewer than WR_OUTST entries.
  - On grant: p_addr_ok = 1. Latch awid = wid = i, awaddr, awsize, wdata, wstrb. Push {i, addr[ADDR_W-1:2]} into the write queue.
  - W_SEND raises awvalid and wvalid together. Each drops independently on its own handshake, in either order or in the same cycle. Return to W_IDLE once both have completed.
- A port may be granted on both slots in the same cycle only if its read and write requests are separate. One port asserts one request at a time, so in practice one grant per port per cycle.
- Read counters:
  - rd_cnt[i] increments on read grant and decrements on rvalid with rid == i.
  - Simultaneous increment and decrement leaves the counter unchanged.
  - Saturation is prevented by the grant condition.
- Responses:
  - p_data_ok[rid] = rvalid, with p_rdata = rdata, in the same cycle (zero latency).
  - p_data_ok[bid] = bvalid. bvalid pops the oldest write-queue entry; the B channel is assumed in-order.
  - R and B completing together for different ports are both reported. p_rdata carries the R data.
- Hazard blocking: a read matching a queued write address stays unaccepted (p_addr_ok = 0) until the matching entry pops. The read is accepted no earlier than the cycle after bvalid.
- Reset mid-transaction: all FSMs, counters and the queue clear immediately. Any responses still in flight are the interconnect's responsibility; it is reset with the same aresetn.

Test Plan:
- Port0 read addr 0x1000, arready after 2 cycles, rvalid rid=0 rdata=0xDEADBEEF 3 cycles later -> p_addr_ok[0] for 1 cycle; arvalid held 3 cycles with araddr=0x1000, arid=0; p_data_ok[0] with p_rdata=0xDEADBEEF.
- Ports 0 and 1 read in the same cycle -> port1 granted first (arid=1), port0 the next idle cycle (arid=0); rid=0 returned before rid=1 routes correctly.
- Port1 issues 3 reads with RD_OUTST=2 and R withheld -> only 2 addr_ok; third accepted the cycle after the first rvalid.
- Port1 writes 0x2000 (wstrb=0xF), then port0 reads 0x2002 -> read blocked until bvalid bid=1; arvalid appears no earlier than the following cycle.
- Write with wready before awready, and another with both in the same cycle -> single AW and single W each, wlast=1, p_data_ok[1] only on bvalid.
- aresetn low during AR_SEND -> arvalid=0 next cycle, rd_cnt=0, new request accepted after reset release.
